// File: rtl/cryptopen_reg_pkg.sv
// Shared definitions for the queued hash-core register interface.
//   offsets_e     : 256-byte region selector taken from address bits [11:8]
//   CTRL_*        : bit positions in the CTRL register (write and read views)
//   ctrl_status_t : 16-bit CTRL read image, [15:8] holds the FIFO count
package cryptopen_reg_pkg;

    typedef enum logic [3:0] {
        OFF_CTRL   = 4'h0,
        OFF_BLOCK  = 4'h1,
        OFF_DIGEST = 4'h2
    } offsets_e;

    // Write view of CTRL byte 0
    localparam int CTRL_PUSH   = 0;
    localparam int CTRL_RESET  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_DVALID = 4;  // write 1 clears dvalid
    localparam int CTRL_LAST   = 5;  // LAST tag attached to a PUSH

    // Read view of CTRL
    localparam int CTRL_FULL   = 3;
    localparam int CTRL_EMPTY  = 5;
    localparam int CTRL_OVF    = 6;

    typedef struct packed {
        logic [7:0] count;
        logic       rsvd7;
        logic       ovf;
        logic       empty;
        logic       dvalid;
        logic       full;
        logic       irq_en;
        logic       reset_q;
        logic       rsvd0;
    } ctrl_status_t;

endpackage

// File: rtl/block_fifo.sv
// Ring-buffer FIFO holding complete hash blocks (block data plus LAST tag).
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : enqueue data_i (ignored while full or flushing)
//   data_i       : entry to enqueue
//   pop_i        : dequeue the head (ignored while empty or flushing)
//   flush_i      : drop all entries; wins over push and pop
//   full_o       : count == Depth
//   empty_o      : count == 0
//   count_o      : number of stored entries
//   data_o       : head entry, forced to zero while empty
module block_fifo #(
    parameter int Width = 513,
    parameter int Depth = 2,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o,
    output logic [Width-1:0] data_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible
    // because data_o is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/queued_reg_interface.sv
// Bus-facing register interface for a hash core with a block FIFO.
// Software fills the staging registers, then PUSHes them (with a LAST tag) into
// the FIFO; the core drains it over block_valid_o/block_ready_i. The digest is
// latched on digest_valid_i and can raise a level interrupt.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   req*_i / reqready_o : request channel (only address bits [11:0] decoded)
//   rsp*_o / rspready_i : registered response, one cycle after the request
//   block_*             : FIFO head towards the core
//   reset_hash_o        : one-cycle core reset pulse after a CTRL RESET
//   digest_i/_valid_i   : digest from the core
//   irq_o               : irq_en & dvalid
// Map: 0x000 CTRL, 0x100 + r*step staging, 0x200 + d*step digest.
module queued_reg_interface
    import cryptopen_reg_pkg::*;
#(
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 32,
    parameter int BlockWidth  = 512,
    parameter int DigestWidth = 256,
    parameter int ByteAlign   = 1,
    parameter int QueueDepth  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DataWidth-1:0]   reqdata_i,
    input  logic [AddrWidth-1:0]   reqaddr_i,
    input  logic                   reqvalid_i,
    input  logic                   reqwrite_i,
    input  logic [DataWidth/8-1:0] reqstrobe_i,
    output logic                   reqready_o,
    input  logic                   rspready_i,
    output logic                   rspvalid_o,
    output logic [DataWidth-1:0]   rspdata_o,
    output logic                   rsperror_o,
    output logic                   block_valid_o,
    input  logic                   block_ready_i,
    output logic [BlockWidth-1:0]  block_o,
    output logic                   last_block_o,
    output logic                   reset_hash_o,
    input  logic [DigestWidth-1:0] digest_i,
    input  logic                   digest_valid_i,
    output logic                   irq_o
);

    localparam int STEP     = (ByteAlign != 0) ? DataWidth / 8 : DataWidth / 32;
    localparam int BLK_REGS = BlockWidth / DataWidth;
    localparam int DIG_REGS = (DigestWidth + DataWidth - 1) / DataWidth;
    localparam int DIG_PAD  = DIG_REGS * DataWidth;
    localparam int STRB_W   = DataWidth / 8;
    localparam int CNT_W    = $clog2(QueueDepth + 1);

    // ---------------- address decode ----------------
    logic [3:0] region;
    logic [7:0] offset;
    logic [7:0] reg_idx;
    logic       aligned, ctrl_hit, blk_hit, dig_hit, hit;
    logic       addr_unused;

    assign region      = reqaddr_i[11:8];
    assign offset      = reqaddr_i[7:0];
    assign reg_idx     = offset / 8'(STEP);
    assign aligned     = (offset % 8'(STEP)) == 8'd0;
    assign ctrl_hit    = (region == OFF_CTRL) && (offset == 8'd0);
    assign blk_hit     = (region == OFF_BLOCK) && aligned && (reg_idx < 8'(BLK_REGS));
    assign dig_hit     = (region == OFF_DIGEST) && aligned && (reg_idx < 8'(DIG_REGS));
    assign hit         = ctrl_hit | blk_hit | dig_hit;
    assign addr_unused = ^reqaddr_i[AddrWidth-1:12];

    // ---------------- control decode ----------------
    logic ctrl_wr, blk_wr, do_reset, push_req, push_rej;
    logic fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic [BlockWidth:0] fifo_head;
    logic [BlockWidth-1:0] staging_block;

    assign ctrl_wr  = reqvalid_i & reqwrite_i & ctrl_hit & reqstrobe_i[0];
    assign blk_wr   = reqvalid_i & reqwrite_i & blk_hit;
    assign do_reset = ctrl_wr & reqdata_i[CTRL_RESET];
    // RESET in the same write overrides the PUSH entirely (no enqueue, no error)
    assign push_req = ctrl_wr & reqdata_i[CTRL_PUSH] & ~do_reset;
    // A coinciding pop does not make room: full is judged on the pre-edge count
    assign push_rej = push_req & fifo_full;
    assign fifo_pop = block_valid_o & block_ready_i;

    // ---------------- staging registers ----------------
    logic [DataWidth-1:0] stage_q [BLK_REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < BLK_REGS; r++) stage_q[r] <= '0;
        end else if (blk_wr) begin
            for (int r = 0; r < BLK_REGS; r++) begin
                if (reg_idx == 8'(r)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (reqstrobe_i[b]) stage_q[r][b*8 +: 8] <= reqdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        staging_block = '0;
        for (int r = 0; r < BLK_REGS; r++) staging_block[r*DataWidth +: DataWidth] = stage_q[r];
    end

    block_fifo #(
        .Width (BlockWidth + 1),
        .Depth (QueueDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req & ~fifo_full),
        .data_i  ({reqdata_i[CTRL_LAST], staging_block}),
        .pop_i   (fifo_pop),
        .flush_i (do_reset),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .data_o  (fifo_head)
    );

    assign block_valid_o = ~fifo_empty;
    assign block_o       = fifo_head[BlockWidth-1:0];
    assign last_block_o  = fifo_head[BlockWidth];

    // ---------------- digest and control state ----------------
    logic [DIG_PAD-1:0]   digest_pad;
    logic [DataWidth-1:0] dig_q [DIG_REGS];
    logic irq_en_q, dvalid_q, ovf_q, reset_hash_q;

    assign digest_pad = DIG_PAD'(digest_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int d = 0; d < DIG_REGS; d++) dig_q[d] <= '0;
        end else if (digest_valid_i) begin
            for (int d = 0; d < DIG_REGS; d++) dig_q[d] <= digest_pad[d*DataWidth +: DataWidth];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_q     <= 1'b0;
            dvalid_q     <= 1'b0;
            ovf_q        <= 1'b0;
            reset_hash_q <= 1'b0;
        end else begin
            reset_hash_q <= do_reset;
            if (ctrl_wr) irq_en_q <= reqdata_i[CTRL_IRQ_EN];
            // A fresh digest wins over any same-cycle clear
            if (digest_valid_i)
                dvalid_q <= 1'b1;
            else if (do_reset || (ctrl_wr && reqdata_i[CTRL_DVALID]))
                dvalid_q <= 1'b0;
            if (do_reset)      ovf_q <= 1'b0;
            else if (push_rej) ovf_q <= 1'b1;
        end
    end

    assign reset_hash_o = reset_hash_q;
    assign irq_o        = irq_en_q & dvalid_q;

    // ---------------- read mux and response registers ----------------
    ctrl_status_t         status;
    logic [DataWidth-1:0] rdata;
    logic reqready_q, rspvalid_q, rsperror_q;
    logic [DataWidth-1:0] rspdata_q;

    always_comb begin
        status         = '0;
        status.count   = 8'(fifo_count);
        status.ovf     = ovf_q;
        status.empty   = fifo_empty;
        status.dvalid  = dvalid_q;
        status.full    = fifo_full;
        status.irq_en  = irq_en_q;
        status.reset_q = reset_hash_q;
        rdata = '0;
        if (ctrl_hit) rdata = DataWidth'(status);
        for (int r = 0; r < BLK_REGS; r++)
            if (blk_hit && reg_idx == 8'(r)) rdata = stage_q[r];
        for (int d = 0; d < DIG_REGS; d++)
            if (dig_hit && reg_idx == 8'(d)) rdata = dig_q[d];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reqready_q <= 1'b0;
            rspvalid_q <= 1'b0;
            rsperror_q <= 1'b0;
            rspdata_q  <= '0;
        end else begin
            // One stall cycle follows every error response
            reqready_q <= ~rsperror_q;
            rspvalid_q <= reqvalid_i & rspready_i & hit;
            rsperror_q <= reqvalid_i & (~hit | push_rej);
            rspdata_q  <= (reqvalid_i & rspready_i & hit & ~reqwrite_i) ? rdata : '0;
        end
    end

    assign reqready_o = reqready_q;
    assign rspvalid_o = rspvalid_q;
    assign rsperror_o = rsperror_q;
    assign rspdata_o  = rspdata_q;

endmodule

// File: tb/tb_queued_reg_interface.sv
// Self-checking bench for queued_reg_interface with default parameters.
// Read responses are checked against a queue of expected data filled when
// each read is issued.
module tb_queued_reg_interface;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [63:0]  reqdata_i = '0;
    logic [31:0]  reqaddr_i = '0;
    logic         reqvalid_i = 1'b0;
    logic         reqwrite_i = 1'b0;
    logic [7:0]   reqstrobe_i = '0;
    logic         reqready_o;
    logic         rspready_i = 1'b1;
    logic         rspvalid_o;
    logic [63:0]  rspdata_o;
    logic         rsperror_o;
    logic         block_valid_o;
    logic         block_ready_i = 1'b0;
    logic [511:0] block_o;
    logic         last_block_o;
    logic         reset_hash_o;
    logic [255:0] digest_i = '0;
    logic         digest_valid_i = 1'b0;
    logic         irq_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    queued_reg_interface dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .reqdata_i      (reqdata_i),
        .reqaddr_i      (reqaddr_i),
        .reqvalid_i     (reqvalid_i),
        .reqwrite_i     (reqwrite_i),
        .reqstrobe_i    (reqstrobe_i),
        .reqready_o     (reqready_o),
        .rspready_i     (rspready_i),
        .rspvalid_o     (rspvalid_o),
        .rspdata_o      (rspdata_o),
        .rsperror_o     (rsperror_o),
        .block_valid_o  (block_valid_o),
        .block_ready_i  (block_ready_i),
        .block_o        (block_o),
        .last_block_o   (last_block_o),
        .reset_hash_o   (reset_hash_o),
        .digest_i       (digest_i),
        .digest_valid_i (digest_valid_i),
        .irq_o          (irq_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ctrl_word(input int cnt, input bit full, input bit empty,
                                               input bit dvalid, input bit irq_en, input bit ovf);
        logic [63:0] w;
        w       = '0;
        w[15:8] = 8'(cnt);
        w[6]    = ovf;
        w[5]    = empty;
        w[4]    = dvalid;
        w[3]    = full;
        w[2]    = irq_en;
        return w;
    endfunction

    function automatic logic [63:0] dig_word(input int d);
        return 64'hA5A5_A5A5_0000_0000 | 64'(d + 1);
    endfunction

    // One request cycle; the response is inspected on the following negedge.
    task automatic bus_op(input logic [11:0] addr, input logic [63:0] data, input logic write,
                          input logic exp_err, input logic [63:0] exp_rd,
                          input logic pop, input logic dig);
        logic [63:0] want;
        @(negedge clk_i);
        reqaddr_i      = {20'h0, addr};
        reqdata_i      = data;
        reqwrite_i     = write;
        reqstrobe_i    = 8'hFF;
        reqvalid_i     = 1'b1;
        block_ready_i  = pop;
        digest_valid_i = dig;
        if (!write && !exp_err) exp_q.push_back(exp_rd);
        @(negedge clk_i);
        reqvalid_i     = 1'b0;
        reqwrite_i     = 1'b0;
        block_ready_i  = 1'b0;
        digest_valid_i = 1'b0;
        checks++;
        if (rsperror_o !== exp_err) begin
            errors++;
            $display("FAIL rsperror addr=%03h got=%b exp=%b", addr, rsperror_o, exp_err);
        end
        if (!write) begin
            checks++;
            if (rspvalid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp addr=%03h got=1 exp=0", addr);
                end else begin
                    want = exp_q.pop_front();
                    if (rspdata_o !== want) begin
                        errors++;
                        $display("FAIL rspdata addr=%03h got=%h exp=%h", addr, rspdata_o, want);
                    end
                end
            end else if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_rsp addr=%03h got=0 exp=1", addr);
                exp_q.delete();
            end
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic e);
        bus_op(a, d, 1'b1, e, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] x, input logic e);
        bus_op(a, 64'h0, 1'b0, e, x, 1'b0, 1'b0);
    endtask

    task automatic pulse_digest();
        @(negedge clk_i);
        digest_valid_i = 1'b1;
        @(negedge clk_i);
        digest_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({reqready_o, rspvalid_o, rsperror_o, block_valid_o, irq_o, reset_hash_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {reqready_o, rspvalid_o, rsperror_o, block_valid_o, irq_o, reset_hash_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (reqready_o !== 1'b0) begin
            errors++;
            $display("FAIL reqready_before_clock got=%b exp=0", reqready_o);
        end
        @(negedge clk_i);
        checks++;
        if (reqready_o !== 1'b1) begin
            errors++;
            $display("FAIL reqready_after_clock got=%b exp=1", reqready_o);
        end
    endtask

    task automatic test_push();
        for (int i = 0; i < 8; i++) wr(12'h100 + 12'(8 * i), 64'(i + 1), 1'b0);
        wr(12'h000, 64'h21, 1'b0);
        checks++;
        if ({block_valid_o, last_block_o} !== 2'b11) begin
            errors++;
            $display("FAIL push_head_flags got=%b exp=11", {block_valid_o, last_block_o});
        end
        checks++;
        if (block_o[63:0] !== 64'd1 || block_o[511:448] !== 64'd8) begin
            errors++;
            $display("FAIL push_block got=%h/%h exp=1/8", block_o[63:0], block_o[511:448]);
        end
        rd(12'h000, ctrl_word(1, 0, 0, 0, 0, 0), 1'b0);
        rd(12'h138, 64'd8, 1'b0);
    endtask

    task automatic test_overflow();
        wr(12'h000, 64'h01, 1'b0);
        rd(12'h000, ctrl_word(2, 1, 0, 0, 0, 0), 1'b0);
        wr(12'h000, 64'h01, 1'b1);
        rd(12'h000, ctrl_word(2, 1, 0, 0, 0, 1), 1'b0);
    endtask

    task automatic test_full_pop();
        bus_op(12'h000, 64'h01, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0);
        checks++;
        if ({block_valid_o, last_block_o} !== 2'b10) begin
            errors++;
            $display("FAIL full_pop_head got=%b exp=10", {block_valid_o, last_block_o});
        end
        rd(12'h000, ctrl_word(1, 0, 0, 0, 0, 1), 1'b0);
    endtask

    task automatic test_digest();
        digest_i = {dig_word(3), dig_word(2), dig_word(1), dig_word(0)};
        wr(12'h000, 64'h04, 1'b0);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_before_digest got=%b exp=0", irq_o);
        end
        pulse_digest();
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_digest got=%b exp=1", irq_o);
        end
        for (int d = 0; d < 4; d++) rd(12'h200 + 12'(8 * d), dig_word(d), 1'b0);
        rd(12'h000, ctrl_word(1, 0, 0, 1, 1, 1), 1'b0);
        bus_op(12'h000, 64'h14, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL digest_over_w1c got=%b exp=1", irq_o);
        end
        wr(12'h000, 64'h14, 1'b0);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c got=%b exp=0", irq_o);
        end
        rd(12'h000, ctrl_word(1, 0, 0, 0, 1, 1), 1'b0);
    endtask

    task automatic test_ctrl_reset();
        wr(12'h000, 64'h01, 1'b0);
        pulse_digest();
        wr(12'h000, 64'h03, 1'b0);
        checks++;
        if ({reset_hash_o, block_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL reset_pulse_start got=%b exp=10", {reset_hash_o, block_valid_o});
        end
        @(negedge clk_i);
        checks++;
        if (reset_hash_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse_end got=%b exp=0", reset_hash_o);
        end
        rd(12'h000, ctrl_word(0, 0, 1, 0, 0, 0), 1'b0);
    endtask

    task automatic test_back_to_back();
        wr(12'h000, 64'h21, 1'b0);
        wr(12'h100, 64'h99, 1'b0);
        bus_op(12'h000, 64'h01, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        checks++;
        if ({block_valid_o, last_block_o} !== 2'b10 || block_o[63:0] !== 64'h99) begin
            errors++;
            $display("FAIL push_pop_head got=%b/%h exp=10/99", {block_valid_o, last_block_o}, block_o[63:0]);
        end
        rd(12'h000, ctrl_word(1, 0, 0, 0, 0, 0), 1'b0);
    endtask

    task automatic test_decode_err();
        logic [11:0] bad [4];
        bad = '{12'h008, 12'h300, 12'h240, 12'h104};
        for (int i = 0; i < 4; i++) begin
            rd(bad[i], 64'h0, 1'b1);
            @(negedge clk_i);
            checks++;
            if (reqready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall addr=%03h got=%b exp=0", bad[i], reqready_o);
            end
            @(negedge clk_i);
            checks++;
            if (reqready_o !== 1'b1) begin
                errors++;
                $display("FAIL unstall addr=%03h got=%b exp=1", bad[i], reqready_o);
            end
        end
        rd(12'h218, dig_word(3), 1'b0);
    endtask

    task automatic test_async_reset();
        wr(12'h000, 64'h25, 1'b0);
        pulse_digest();
        @(negedge clk_i);
        reqaddr_i  = 32'h100;
        reqwrite_i = 1'b0;
        reqvalid_i = 1'b1;
        #2;
        checks++;
        if ({block_valid_o, irq_o} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_state got=%b exp=11", {block_valid_o, irq_o});
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({reqready_o, rspvalid_o, rsperror_o, block_valid_o, last_block_o, reset_hash_o, irq_o} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset_flags got=%b exp=0000000",
                     {reqready_o, rspvalid_o, rsperror_o, block_valid_o, last_block_o, reset_hash_o, irq_o});
        end
        checks++;
        if (block_o !== '0 || rspdata_o !== '0) begin
            errors++;
            $display("FAIL async_reset_data got=%h/%h exp=0/0", block_o[63:0], rspdata_o);
        end
        reqvalid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        rd(12'h000, ctrl_word(0, 0, 1, 0, 0, 0), 1'b0);
        rd(12'h100, 64'h0, 1'b0);
        rd(12'h200, 64'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_push();
        test_overflow();
        test_full_pop();
        test_digest();
        test_ctrl_reset();
        test_back_to_back();
        test_decode_err();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
